// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The state enum, the multiply/divide latency and the load-use hazard test live here.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDBUSY = 2'd1,
        HALT   = 2'd2
    } haz_state_t;

    localparam int                  MD_CNT_W = 3;
    localparam logic [MD_CNT_W-1:0] MD_LAT   = 3'd4;
    localparam int                  STAT_W   = 16;

    // Register 0 is hardwired to zero, so a load into r0 can never create a dependency.
    function automatic logic load_use_hazard(
        input logic       memtoreg,
        input logic       regwrite,
        input logic [4:0] wb_reg,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return memtoreg & regwrite & (wb_reg != 5'd0) &
               ((uses_rs & (rs == wb_reg)) | (uses_rt & (rt == wb_reg)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// haz_sat_cnt: saturating up-counter with synchronous clear, used for hazard statistics.
// It stops at all-ones instead of wrapping.
module haz_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, control-transfer flushes, HI/LO freeze and halt.
// Define HAZ_STATS_EN to build the stall/flush statistic counters; otherwise they read as 0.
//
// state  | meaning
// RUN    | normal issue; stalls on load-use, flushes on taken control transfer
// MDBUSY | pipeline frozen while the multi-cycle HI/LO operation completes
// HALT   | frozen after a retired syscall until go is asserted
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        CLR,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        EX_MemtoReg,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_WbRegNum,
    input  logic        EX_BranchTaken,
    input  logic        EX_J,
    input  logic        EX_ERET,
    input  logic        EX_MultDiv,
    input  logic        WB_SYSCALL,
    input  logic        go,
    output logic        PC_EN,
    output logic        IFID_EN,
    output logic        IFID_CLR,
    output logic        IDEX_EN,
    output logic        IDEX_CLR,
    output logic        IDEX_bb,
    output logic        EXMEM_EN,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    haz_state_t          state;
    haz_state_t          state_next;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_next;
    logic                flush;
    logic                load_use;

    assign flush    = EX_BranchTaken | EX_J | EX_ERET;
    assign load_use = load_use_hazard(EX_MemtoReg, EX_RegWrite, EX_WbRegNum,
                                      ID_rs, ID_rt, ID_UsesRs, ID_UsesRt);

    always_ff @(posedge clk) begin
        if (CLR) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        PC_EN       = 1'b1;
        IFID_EN     = 1'b1;
        IFID_CLR    = 1'b0;
        IDEX_EN     = 1'b1;
        IDEX_CLR    = 1'b0;
        IDEX_bb     = 1'b0;
        EXMEM_EN    = 1'b1;
        halted      = 1'b0;

        if (CLR) begin
            PC_EN    = 1'b0;
            IFID_EN  = 1'b0;
            IDEX_EN  = 1'b0;
            EXMEM_EN = 1'b0;
            IFID_CLR = 1'b1;
            IDEX_CLR = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    // A flush squashes the dependent instruction, so it overrides the stall.
                    if (flush) begin
                        IFID_CLR = 1'b1;
                        IDEX_CLR = 1'b1;
                    end else if (load_use) begin
                        PC_EN   = 1'b0;
                        IFID_EN = 1'b0;
                        IDEX_bb = 1'b1;
                    end

                    if (WB_SYSCALL) begin
                        state_next = HALT;
                    end else if (EX_MultDiv && !flush) begin
                        state_next  = MDBUSY;
                        md_cnt_next = MD_LAT;
                    end
                end

                MDBUSY: begin
                    PC_EN    = 1'b0;
                    IFID_EN  = 1'b0;
                    IDEX_EN  = 1'b0;
                    EXMEM_EN = 1'b0;
                    if (WB_SYSCALL) begin
                        state_next  = HALT;
                        md_cnt_next = '0;
                    end else begin
                        md_cnt_next = md_cnt - 1'b1;
                        if (md_cnt == MD_CNT_W'(1)) begin
                            state_next = RUN;
                        end
                    end
                end

                HALT: begin
                    PC_EN    = 1'b0;
                    IFID_EN  = 1'b0;
                    IDEX_EN  = 1'b0;
                    EXMEM_EN = 1'b0;
                    halted   = 1'b1;
                    if (go) begin
                        state_next = RUN;
                    end
                end

                default: begin
                    state_next  = RUN;
                    md_cnt_next = '0;
                end
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !CLR && !PC_EN;
    assign flush_inc = !CLR && (state == RUN) && flush;

    haz_sat_cnt #(.W(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (CLR),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    haz_sat_cnt #(.W(STAT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (CLR),
        .inc   (flush_inc),
        .count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences,
// and randomized traffic against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        CLR;
    logic [4:0]  ID_rs, ID_rt, EX_WbRegNum;
    logic        ID_UsesRs, ID_UsesRt, EX_MemtoReg, EX_RegWrite;
    logic        EX_BranchTaken, EX_J, EX_ERET, EX_MultDiv, WB_SYSCALL, go;
    logic        PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, IDEX_bb, EXMEM_EN, halted;
    logic [15:0] stall_cycles, flush_count;

    pipe_hazard_ctrl dut (
        .clk(clk), .CLR(CLR),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_WbRegNum(EX_WbRegNum),
        .EX_BranchTaken(EX_BranchTaken), .EX_J(EX_J), .EX_ERET(EX_ERET),
        .EX_MultDiv(EX_MultDiv), .WB_SYSCALL(WB_SYSCALL), .go(go),
        .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_CLR(IFID_CLR), .IDEX_EN(IDEX_EN),
        .IDEX_CLR(IDEX_CLR), .IDEX_bb(IDEX_bb), .EXMEM_EN(EXMEM_EN), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       m2r;
        logic       rw;
        logic [4:0] wb;
        logic       br;
        logic       j;
        logic       eret;
        logic       md;
        logic       sys;
        logic       go;
        logic       clr;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    // Output bundle order: PC_EN IFID_EN IFID_CLR IDEX_EN IDEX_CLR IDEX_bb EXMEM_EN halted
    localparam logic [7:0] O_RUN   = 8'b1101_0010;
    localparam logic [7:0] O_STALL = 8'b0001_0110;
    localparam logic [7:0] O_FLUSH = 8'b1111_1010;
    localparam logic [7:0] O_CLR   = 8'b0010_1000;
    localparam logic [7:0] O_FROZE = 8'b0000_0000;
    localparam logic [7:0] O_HALT  = 8'b0000_0001;

    int checks   = 0;
    int failures = 0;

    // Model state: halted flag, remaining frozen cycles, and statistic totals.
    bit         halted_m;
    int         md_left;
    int         stall_m;
    int         flush_m;
    logic [7:0] last_outs;

    function automatic logic [7:0] outs();
        return {PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, IDEX_bb, EXMEM_EN, halted};
    endfunction

    function automatic stim_t mk(int rs, int rt, bit urs, bit urt, bit m2r, bit rw, int wb,
                                 bit br, bit j, bit eret, bit md, bit sys, bit g, bit clr);
        stim_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.m2r = m2r; v.rw = rw;
        v.wb = 5'(wb); v.br = br; v.j = j; v.eret = eret; v.md = md; v.sys = sys;
        v.go = g; v.clr = clr;
        return v;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [7:0] model_out(stim_t v);
        bit hz;
        hz = v.m2r && v.rw && (v.wb != 0) &&
             ((v.urs && v.rs == v.wb) || (v.urt && v.rt == v.wb));
        if (v.clr)               return O_CLR;
        if (halted_m)            return O_HALT;
        if (md_left > 0)         return O_FROZE;
        if (v.br | v.j | v.eret) return O_FLUSH;
        if (hz)                  return O_STALL;
        return O_RUN;
    endfunction

    task automatic model_update(stim_t v);
        logic [7:0] o;
        bit         fl;
        o  = model_out(v);
        fl = v.br | v.j | v.eret;
        if (v.clr) begin
            halted_m = 0; md_left = 0; stall_m = 0; flush_m = 0;
        end else begin
            if (!o[7] && stall_m < 65535) stall_m++;
            if (!halted_m && md_left == 0 && fl && flush_m < 65535) flush_m++;
            if (halted_m) begin
                if (v.go) halted_m = 0;
            end else if (v.sys) begin
                halted_m = 1; md_left = 0;
            end else if (md_left > 0) begin
                md_left--;
            end else if (v.md && !fl) begin
                md_left = 4;
            end
        end
    endtask

    task automatic drive(stim_t v);
        ID_rs = v.rs; ID_rt = v.rt; ID_UsesRs = v.urs; ID_UsesRt = v.urt;
        EX_MemtoReg = v.m2r; EX_RegWrite = v.rw; EX_WbRegNum = v.wb;
        EX_BranchTaken = v.br; EX_J = v.j; EX_ERET = v.eret; EX_MultDiv = v.md;
        WB_SYSCALL = v.sys; go = v.go; CLR = v.clr;
    endtask

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, compare outputs and statistics against the model, advance.
    task automatic step(string name, stim_t v);
        drive(v);
        @(negedge clk);
        last_outs = outs();
        check8(name, last_outs, model_out(v));
        check_int({name, "_stall"}, int'(stall_cycles), STATS ? stall_m : 0);
        check_int({name, "_flush"}, int'(flush_count), STATS ? flush_m : 0);
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        halted_m = 0; md_left = 0; stall_m = 0; flush_m = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        check8("reset_outs", last_outs, O_CLR);

        // Single-cycle RUN behaviour; none of these leave RUN.
        tbl.push_back('{"idle",        idle(),                                          O_RUN});
        tbl.push_back('{"lu_rs",       mk(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0),    O_STALL});
        tbl.push_back('{"lu_r0",       mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0),    O_RUN});
        tbl.push_back('{"lu_flush",    mk(8, 0, 1, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0),    O_FLUSH});
        tbl.push_back('{"lu_rt",       mk(0, 17, 0, 1, 1, 1, 17, 0, 0, 0, 0, 0, 0, 0),  O_STALL});
        tbl.push_back('{"rt_unused",   mk(0, 17, 0, 0, 1, 1, 17, 0, 0, 0, 0, 0, 0, 0),  O_RUN});
        tbl.push_back('{"no_memtoreg", mk(8, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0),    O_RUN});
        tbl.push_back('{"no_regwr",    mk(8, 0, 1, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0),    O_RUN});
        tbl.push_back('{"jump",        mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),    O_FLUSH});
        tbl.push_back('{"eret",        mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0),    O_FLUSH});
        tbl.push_back('{"go_in_run",   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),    O_RUN});
        tbl.push_back('{"clr_run",     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),    O_CLR});
        tbl.push_back('{"md_flush",    mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0),    O_FLUSH});
        tbl.push_back('{"after_mdfl",  idle(),                                          O_RUN});
        foreach (tbl[i]) begin
            drive(tbl[i].s);
            @(negedge clk);
            check8(tbl[i].name, outs(), tbl[i].exp);
            @(posedge clk);
            model_update(tbl[i].s);
            #1;
        end

        // Multiply/divide: one pulse freezes exactly four cycles.
        step("md_clr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("md_pulse", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        begin
            int frozen;
            frozen = 0;
            for (int k = 0; k < 8; k++) begin
                // A load-use and another MultDiv during the freeze must be ignored.
                step("md_body", mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 1, 0, 0, 0));
                if (last_outs == O_FROZE) frozen++;
                if (last_outs != O_FROZE) break;
            end
            check_int("md_frozen_cycles", frozen, 4);
            check8("md_back_to_run", last_outs, O_STALL);
            drive(idle());
            @(negedge clk);
            check_int("md_stall_stat", int'(stall_cycles), STATS ? 5 : 0);
        end

        // Halt entered from the 2nd MDBUSY cycle, held, then released by go.
        step("h_clr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("h_md", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("h_mdb1", idle());
        step("h_mdb2_sys", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        check8("h_mdb2_frozen", last_outs, O_FROZE);
        for (int k = 0; k < 10; k++) begin
            step("h_hold", mk(5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 1, 1, 0, 0));
            check8("h_hold_const", last_outs, O_HALT);
        end
        step("h_go", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        check8("h_go_still_halted", last_outs, O_HALT);
        step("h_run", idle());
        check8("h_run_again", last_outs, O_RUN);

        // Reset in the 3rd MDBUSY cycle aborts to RUN with statistics cleared.
        step("r_clr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("r_md", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("r_mdb1", idle());
        step("r_mdb2", idle());
        step("r_mdb3_clr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        check8("r_clr_outs", last_outs, O_CLR);
        step("r_after", idle());
        check8("r_after_run", last_outs, O_RUN);
        check_int("r_stall_zero", int'(stall_cycles), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            stim_t v;
            v.rs   = 5'($urandom_range(0, 3));
            v.rt   = 5'($urandom_range(0, 3));
            v.urs  = ($urandom_range(0, 1) == 1);
            v.urt  = ($urandom_range(0, 1) == 1);
            v.m2r  = ($urandom_range(0, 2) != 0);
            v.rw   = ($urandom_range(0, 3) != 0);
            v.wb   = 5'($urandom_range(0, 3));
            v.br   = ($urandom_range(0, 7) == 0);
            v.j    = ($urandom_range(0, 11) == 0);
            v.eret = ($urandom_range(0, 15) == 0);
            v.md   = ($urandom_range(0, 7) == 0);
            v.sys  = ($urandom_range(0, 24) == 0);
            v.go   = ($urandom_range(0, 3) == 0);
            v.clr  = ($urandom_range(0, 59) == 0);
            step("rand", v);
        end

`ifdef HAZ_STATS_EN
        // Flush counter saturation.
        step("s_clr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 65540; k++) begin
            @(posedge clk);
            model_update(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        check_int("sat_flush", int'(flush_count), 65535);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("sat_flush_held", int'(flush_count), 65535);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have port CLR, input, 1 bit: synchronous, active-high reset of this block.
REQ-003 SHALL have ports ID_rs and ID_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have ports ID_UsesRs and ID_UsesRt, input, 1 bit each: the ID instruction actually reads rs or rt.
REQ-005 SHALL have ports EX_MemtoReg, EX_RegWrite (input, 1 bit each) and EX_WbRegNum (input, 5 bits): load/writeback info for the instruction in EX.
REQ-006 SHALL have ports EX_BranchTaken, EX_J, EX_ERET, input, 1 bit each: control transfer resolved in EX.
REQ-007 SHALL have port EX_MultDiv, input, 1 bit: a multi-cycle HI/LO operation is in EX.
REQ-008 SHALL have ports WB_SYSCALL (input, 1 bit: halt request retiring in WB) and go (input, 1 bit: resume from halt).
REQ-009 SHALL have outputs PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, IDEX_bb and EXMEM_EN, 1 bit each: control of the pipeline registers.
REQ-010 SHALL have output halted, 1 bit: the block is in HALT.
REQ-011 SHALL have outputs stall_cycles and flush_count, 16 bits each: statistics.

Function
REQ-012 SHALL implement a state machine with three states: RUN, MDBUSY and HALT; outputs are combinational from the state and the current inputs.
REQ-013 In RUN, default outputs SHALL be: all *_EN=1; IFID_CLR, IDEX_CLR and IDEX_bb =0.
REQ-014 Load-use hazard SHALL be EX_MemtoReg & EX_RegWrite & EX_WbRegNum!=0 & ((ID_UsesRs & ID_rs==EX_WbRegNum) | (ID_UsesRt & ID_rt==EX_WbRegNum)).
REQ-015 On a load-use hazard in RUN, outputs SHALL be PC_EN=0, IFID_EN=0, IDEX_EN=1, IDEX_bb=1 (exactly one bubble per hazard cycle).
REQ-016 Flush SHALL be EX_BranchTaken | EX_J | EX_ERET; in RUN it SHALL drive IFID_CLR=1, IDEX_CLR=1, PC_EN=1, and IDEX_bb=0.
REQ-017 When flush and load-use occur in the same cycle, flush SHALL win and no stall is taken.
REQ-018 When EX_MultDiv=1 in RUN with no flush, the block SHALL go to MDBUSY next cycle and load an internal counter with MD_LAT.
REQ-019 In MDBUSY, PC_EN, IFID_EN, IDEX_EN and EXMEM_EN SHALL all be 0 and every CLR/bb output SHALL be 0; the counter SHALL decrement each cycle, returning to RUN after the cycle in which it equals 1 (exactly MD_LAT frozen cycles).
REQ-020 A WB_SYSCALL=1 in RUN or MDBUSY SHALL cause entry to HALT next cycle; it SHALL take priority over every other transition.
REQ-021 In HALT, all *_EN SHALL be 0 and halted SHALL be 1; go=1 SHALL return the block to RUN next cycle, and go SHALL be ignored in other states.
REQ-022 A load-use hazard or EX_MultDiv occurring in MDBUSY or HALT SHALL be ignored until the block is back in RUN.

Reset
REQ-023 CLR=1 at a rising edge SHALL set the state to RUN and the counter to 0, and SHALL zero stall_cycles and flush_count.
REQ-024 While CLR=1, outputs SHALL be: all *_EN=0, IFID_CLR=1, IDEX_CLR=1, IDEX_bb=0 and halted=0; CLR mid-MDBUSY or mid-HALT SHALL abort to RUN.

Configuration
REQ-025 With macro HAZ_STATS_EN defined, stall_cycles SHALL count cycles with PC_EN=0 outside CLR, and flush_count SHALL count flush cycles in RUN; both SHALL saturate at 16'hFFFF.
REQ-026 Without HAZ_STATS_EN, stall_cycles and flush_count SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-027 Package pipe_hazard_pkg SHALL hold the state enum (RUN, MDBUSY, HALT) and the constant MD_LAT=4 (counter width 3 bits).
REQ-028 Sub-module haz_sat_cnt (a 16-bit saturating counter with synchronous clear) SHALL be instantiated twice, only under HAZ_STATS_EN.

Verification
REQ-029 Load-use bubble: EX_MemtoReg=1, EX_RegWrite=1, EX_WbRegNum=8, ID_rs=8, ID_UsesRs=1 -> PC_EN=0, IFID_EN=0, IDEX_bb=1 that cycle; repeating with EX_WbRegNum=0 -> no stall.
REQ-030 Flush vs load-use: same stimulus as REQ-029 plus EX_BranchTaken=1 -> IFID_CLR=1, IDEX_CLR=1, PC_EN=1, IDEX_bb=0.
REQ-031 MultDiv: pulse EX_MultDiv for 1 cycle -> exactly 4 cycles with all EN=0, then RUN; with HAZ_STATS_EN, stall_cycles=4.
REQ-032 Halt: WB_SYSCALL=1 during the 2nd MDBUSY cycle -> HALT next cycle, halted=1 held for 10 cycles; go=1 -> RUN next cycle.
REQ-033 Reset mid-op: CLR=1 in the 3rd MDBUSY cycle -> next cycle RUN, counters 0, and outputs follow REQ-024 while CLR is high.
REQ-034 Saturation (HAZ_STATS_EN): force 65540 flush cycles -> flush_count=16'hFFFF and held.
